// File: rtl/alarm_clock_core_if.sv
// Button/display bundle between the board top and alarm_clock_core.
// master = board side (drives buttons), slave = clock core (drives display state).
interface alarm_clock_core_if #(
   parameter int NUM_ALARMS = 2
);
   logic                  tick_en;
   logic                  btn_mode;
   logic                  btn_sel;
   logic                  btn_up;
   logic                  btn_down;
   logic [15:0]           disp;
   logic [5:0]            sec;
   logic [1:0]            mode;
   logic                  field;
   logic [3:0]            alarm_idx;
   logic [NUM_ALARMS-1:0] alarm_en;
   logic                  ring;

   modport master (
      output tick_en, btn_mode, btn_sel, btn_up, btn_down,
      input  disp, sec, mode, field, alarm_idx, alarm_en, ring
   );

   modport slave (
      input  tick_en, btn_mode, btn_sel, btn_up, btn_down,
      output disp, sec, mode, field, alarm_idx, alarm_en, ring
   );
endinterface

// File: rtl/alarm_clock_core.sv
// Time-of-day clock with NUM_ALARMS programmable alarms, button-driven editing and ring control.
// Snooze on btn_up while ringing is compiled in only when ALARM_SNOOZE_EN is defined.
module alarm_clock_core #(
   parameter int TICKS_PER_SEC = 100000000,
   parameter int NUM_ALARMS    = 2,
   parameter int SNOOZE_MIN    = 9,
   parameter int RING_MIN      = 1
) (
   input logic               clk,
   input logic               rst,
   alarm_clock_core_if.slave bus
);

   localparam int PW = $clog2(TICKS_PER_SEC);

   typedef enum logic [1:0] {
      MODE_RUN       = 2'd0,
      MODE_SET_TIME  = 2'd1,
      MODE_SET_ALARM = 2'd2
   } modeT;

   if (TICKS_PER_SEC < 2 || NUM_ALARMS < 1 || NUM_ALARMS > 16 ||
       SNOOZE_MIN < 1 || SNOOZE_MIN > 59 || RING_MIN < 1 || RING_MIN > 59) begin : gBadParams
      $error("alarm_clock_core: parameter out of legal range");
   end

   function automatic logic [5:0] wrapStep(input logic [5:0] value, input logic [5:0] maxValue,
                                           input logic up);
      if (up) return (value == maxValue) ? 6'd0 : value + 6'd1;
      return (value == 6'd0) ? maxValue : value - 6'd1;
   endfunction

   logic [PW-1:0]         prescQ, prescD;
   logic [5:0]            secQ, secD;
   logic [5:0]            minQ, minD;
   logic [4:0]            hourQ, hourD;
   modeT                  modeQ, modeD;
   logic                  fieldQ, fieldD;
   logic [3:0]            idxQ, idxD;
   logic [4:0]            shHourQ, shHourD;
   logic [5:0]            shMinQ, shMinD;
   logic [4:0]            alHourQ [NUM_ALARMS];
   logic [4:0]            alHourD [NUM_ALARMS];
   logic [5:0]            alMinQ [NUM_ALARMS];
   logic [5:0]            alMinD [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] alEnQ, alEnD;
   logic                  ringQ, ringD;
   logic [5:0]            ringCntQ, ringCntD;
`ifdef ALARM_SNOOZE_EN
   logic                  snzArmQ, snzArmD;
   logic [4:0]            snzHourQ, snzHourD;
   logic [5:0]            snzMinQ, snzMinD;
   logic [6:0]            snzSum;
   logic                  snoozeReq;
`endif

   logic       editUp, editDown, editEn, commit, advance, dismiss;
   logic       secTick, minCarry, effCarry, matchHit;
   logic [4:0] carryHour, nextSlotHour;
   logic [5:0] carryMin, nextSlotMin;

   // NOTE: every variable gets a default before any branch so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      prescD   = prescQ;
      secD     = secQ;
      minD     = minQ;
      hourD    = hourQ;
      modeD    = modeQ;
      fieldD   = fieldQ;
      idxD     = idxQ;
      shHourD  = shHourQ;
      shMinD   = shMinQ;
      alHourD  = alHourQ;
      alMinD   = alMinQ;
      alEnD    = alEnQ;
      ringD    = ringQ;
      ringCntD = ringCntQ;
`ifdef ALARM_SNOOZE_EN
      snzArmD   = snzArmQ;
      snzHourD  = snzHourQ;
      snzMinD   = snzMinQ;
      snoozeReq = 1'b0;
      snzSum    = {1'b0, minQ} + 7'(SNOOZE_MIN);
`endif
      editUp       = bus.btn_up & ~bus.btn_down;
      editDown     = bus.btn_down & ~bus.btn_up;
      editEn       = 1'b0;
      commit       = 1'b0;
      advance      = 1'b0;
      dismiss      = 1'b0;
      matchHit     = 1'b0;
      nextSlotHour = '0;
      nextSlotMin  = '0;

      for (int i = 0; i < NUM_ALARMS; i++) begin
         if (idxQ + 4'd1 == 4'(i)) begin
            nextSlotHour = alHourQ[i];
            nextSlotMin  = alMinQ[i];
         end
      end

      // Button priority: mode, then sel, then up/down.
      unique case (modeQ)
         MODE_RUN: begin
            if (bus.btn_mode) begin
               modeD   = MODE_SET_TIME;
               fieldD  = 1'b0;
               shHourD = hourQ;
               shMinD  = minQ;
            end else if (bus.btn_sel) begin
               dismiss = ringQ;
`ifdef ALARM_SNOOZE_EN
            end else if (editUp) begin
               snoozeReq = ringQ;
`endif
            end
         end
         MODE_SET_TIME: begin
            if (bus.btn_mode) begin
               modeD   = MODE_SET_ALARM;
               idxD    = 4'd0;
               fieldD  = 1'b0;
               shHourD = alHourQ[0];
               shMinD  = alMinQ[0];
            end else if (bus.btn_sel) begin
               if (!fieldQ) fieldD = 1'b1;
               else         commit = 1'b1;
            end else begin
               editEn = 1'b1;
            end
         end
         MODE_SET_ALARM: begin
            if (bus.btn_mode) begin
               for (int i = 0; i < NUM_ALARMS; i++)
                  if (fieldQ && idxQ == 4'(i)) alEnD[i] = 1'b0;
               advance = 1'b1;
            end else if (bus.btn_sel) begin
               if (!fieldQ) begin
                  fieldD = 1'b1;
               end else begin
                  for (int i = 0; i < NUM_ALARMS; i++) begin
                     if (idxQ == 4'(i)) begin
                        alHourD[i] = shHourQ;
                        alMinD[i]  = shMinQ;
                        alEnD[i]   = 1'b1;
                     end
                  end
                  advance = 1'b1;
               end
            end else begin
               editEn = 1'b1;
            end
         end
         default: modeD = MODE_RUN;
      endcase

      if (editEn && (editUp || editDown)) begin
         if (!fieldQ) shMinD  = wrapStep(shMinQ, 6'd59, editUp);
         else         shHourD = 5'(wrapStep({1'b0, shHourQ}, 6'd23, editUp));
      end

      if (advance) begin
         fieldD = 1'b0;
         if (idxQ == 4'(NUM_ALARMS - 1)) begin
            modeD = MODE_RUN;
            idxD  = 4'd0;
         end else begin
            idxD    = idxQ + 4'd1;
            shHourD = nextSlotHour;
            shMinD  = nextSlotMin;
         end
      end

      secTick   = bus.tick_en && (prescQ == PW'(TICKS_PER_SEC - 1));
      minCarry  = secTick && (secQ == 6'd59);
      carryMin  = (minQ == 6'd59) ? 6'd0 : minQ + 6'd1;
      carryHour = (minQ != 6'd59) ? hourQ : ((hourQ == 5'd23) ? 5'd0 : hourQ + 5'd1);

      // A commit replaces the live time outright, so it swallows any carry in the same cycle.
      effCarry = minCarry && !commit;
      if (commit) begin
         hourD  = shHourQ;
         minD   = shMinQ;
         secD   = 6'd0;
         prescD = '0;
         modeD  = MODE_RUN;
         fieldD = 1'b0;
      end else if (secTick) begin
         prescD = '0;
         secD   = (secQ == 6'd59) ? 6'd0 : secQ + 6'd1;
         if (minCarry) begin
            minD  = carryMin;
            hourD = carryHour;
         end
      end else if (bus.tick_en) begin
         prescD = prescQ + PW'(1);
      end

      for (int i = 0; i < NUM_ALARMS; i++)
         if (effCarry && alEnQ[i] && alHourQ[i] == carryHour && alMinQ[i] == carryMin)
            matchHit = 1'b1;

      if (matchHit) begin
         ringD    = 1'b1;
         ringCntD = 6'(RING_MIN);
`ifdef ALARM_SNOOZE_EN
         snzArmD  = 1'b0;
      end else if (effCarry && snzArmQ && snzHourQ == carryHour && snzMinQ == carryMin) begin
         ringD    = 1'b1;
         ringCntD = 6'(RING_MIN);
         snzArmD  = 1'b0;
`endif
      end else if (dismiss) begin
         ringD   = 1'b0;
`ifdef ALARM_SNOOZE_EN
         snzArmD = 1'b0;
      end else if (snoozeReq) begin
         ringD   = 1'b0;
         snzArmD = 1'b1;
         if (snzSum >= 7'd60) begin
            snzMinD  = 6'(snzSum - 7'd60);
            snzHourD = (hourQ == 5'd23) ? 5'd0 : hourQ + 5'd1;
         end else begin
            snzMinD  = snzSum[5:0];
            snzHourD = hourQ;
         end
`endif
      end else if (ringQ && effCarry) begin
         ringCntD = ringCntQ - 6'd1;
         if (ringCntQ <= 6'd1) ringD = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples
   // the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         prescQ   <= '0;
         secQ     <= '0;
         minQ     <= '0;
         hourQ    <= '0;
         modeQ    <= MODE_RUN;
         fieldQ   <= 1'b0;
         idxQ     <= '0;
         shHourQ  <= '0;
         shMinQ   <= '0;
         alEnQ    <= '0;
         ringQ    <= 1'b0;
         ringCntQ <= '0;
         // NOTE: the slot array is reset explicitly because its 00:00 contents are visible
         // when editing right after reset; a plain storage RAM would not be reset.
         for (int i = 0; i < NUM_ALARMS; i++) begin
            alHourQ[i] <= '0;
            alMinQ[i]  <= '0;
         end
`ifdef ALARM_SNOOZE_EN
         snzArmQ  <= 1'b0;
         snzHourQ <= '0;
         snzMinQ  <= '0;
`endif
      end else begin
         prescQ   <= prescD;
         secQ     <= secD;
         minQ     <= minD;
         hourQ    <= hourD;
         modeQ    <= modeD;
         fieldQ   <= fieldD;
         idxQ     <= idxD;
         shHourQ  <= shHourD;
         shMinQ   <= shMinD;
         alHourQ  <= alHourD;
         alMinQ   <= alMinD;
         alEnQ    <= alEnD;
         ringQ    <= ringD;
         ringCntQ <= ringCntD;
`ifdef ALARM_SNOOZE_EN
         snzArmQ  <= snzArmD;
         snzHourQ <= snzHourD;
         snzMinQ  <= snzMinD;
`endif
      end
   end

   assign bus.disp      = (modeQ == MODE_RUN) ? {3'b000, hourQ, 2'b00, minQ}
                                              : {3'b000, shHourQ, 2'b00, shMinQ};
   assign bus.sec       = secQ;
   assign bus.mode      = modeQ;
   assign bus.field     = fieldQ;
   assign bus.alarm_idx = idxQ;
   assign bus.alarm_en  = alEnQ;
   assign bus.ring      = ringQ;

endmodule
